// File: rtl/ps2_key_event_gen_if.sv
// PS/2 pin inputs plus the decoded key event word and per-byte status strobes.
// master: the event generator side; slave: the consumer/driver of the pins.
interface ps2_key_event_gen_if;
  logic        ps2_clk;
  logic        ps2_data;
  logic [10:0] ps2_key;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        frame_err;

  modport master (
    input  ps2_clk, ps2_data,
    output ps2_key, byte_valid, byte_data, frame_err
  );

  modport slave (
    output ps2_clk, ps2_data,
    input  ps2_key, byte_valid, byte_data, frame_err
  );
endinterface

// File: rtl/ps2_key_event_gen.sv
// PS/2 keyboard receiver and make/break/extended parser producing a toggle-format key event word.
// Optional feature macro: PS2_PARITY_CHECK_EN (reject frames with bad odd parity).
module ps2_key_event_gen #(
  parameter real CLK_FREQ   = 96.0,
  parameter int  FILTER_LEN = 8,
  parameter int  TIMEOUT_US = 100
) (
  input logic                 clk,
  input logic                 reset_n,
  ps2_key_event_gen_if.master ps2
);
  localparam int TMO_CYC = $rtoi(CLK_FREQ * real'(TIMEOUT_US));
  localparam int TMO_W   = $clog2(TMO_CYC + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_PARITY, ST_STOP} rx_state_t;

  logic [1:0]            clk_sync_reg, data_sync_reg;
  logic [FILTER_LEN-1:0] filt_hist_reg, filt_hist_next;
  logic                  filt_lvl_reg, filt_lvl_next;
  logic                  strobe_reg;
  logic                  rx_bit;

  rx_state_t             state_reg, state_next;
  logic [2:0]            bit_cnt_reg, bit_cnt_next;
  logic [7:0]            shift_reg, shift_next;
  logic                  par_ok_reg, par_ok_next;
  logic [TMO_W-1:0]      tmo_cnt_reg, tmo_cnt_next;
  logic                  byte_valid_reg, byte_valid_next;
  logic [7:0]            byte_data_reg, byte_data_next;
  logic                  frame_err_reg, frame_err_next;

  logic                  ext_reg, brk_reg;
  logic [2:0]            skip_reg;
  logic [10:0]           key_reg;

  // The filtered level only moves once the whole history window agrees.
  assign filt_hist_next = {filt_hist_reg[FILTER_LEN-2:0], clk_sync_reg[1]};
  assign filt_lvl_next  = (&filt_hist_next) ? 1'b1 :
                          (~|filt_hist_next) ? 1'b0 : filt_lvl_reg;
  assign rx_bit         = data_sync_reg[1];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      clk_sync_reg  <= 2'b11;
      data_sync_reg <= 2'b11;
      filt_hist_reg <= '1;
      filt_lvl_reg  <= 1'b1;
      strobe_reg    <= 1'b0;
    end else begin
      clk_sync_reg  <= {clk_sync_reg[0], ps2.ps2_clk};
      data_sync_reg <= {data_sync_reg[0], ps2.ps2_data};
      filt_hist_reg <= filt_hist_next;
      filt_lvl_reg  <= filt_lvl_next;
      strobe_reg    <= filt_lvl_reg & ~filt_lvl_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg      <= ST_IDLE;
      bit_cnt_reg    <= '0;
      shift_reg      <= '0;
      par_ok_reg     <= 1'b0;
      tmo_cnt_reg    <= '0;
      byte_valid_reg <= 1'b0;
      byte_data_reg  <= '0;
      frame_err_reg  <= 1'b0;
    end else begin
      state_reg      <= state_next;
      bit_cnt_reg    <= bit_cnt_next;
      shift_reg      <= shift_next;
      par_ok_reg     <= par_ok_next;
      tmo_cnt_reg    <= tmo_cnt_next;
      byte_valid_reg <= byte_valid_next;
      byte_data_reg  <= byte_data_next;
      frame_err_reg  <= frame_err_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    bit_cnt_next    = bit_cnt_reg;
    shift_next      = shift_reg;
    par_ok_next     = par_ok_reg;
    tmo_cnt_next    = tmo_cnt_reg;
    byte_valid_next = 1'b0;
    byte_data_next  = byte_data_reg;
    frame_err_next  = 1'b0;
    if (state_reg != ST_IDLE) tmo_cnt_next = tmo_cnt_reg + TMO_W'(1);
    // A strobe takes priority over a simultaneous timeout expiry.
    if (strobe_reg) begin
      tmo_cnt_next = '0;
      case (state_reg)
        ST_IDLE: begin
          if (!rx_bit) begin
            state_next   = ST_DATA;
            bit_cnt_next = '0;
          end else begin
            frame_err_next = 1'b1;
          end
        end
        ST_DATA: begin
          shift_next   = {rx_bit, shift_reg[7:1]};
          bit_cnt_next = bit_cnt_reg + 3'd1;
          if (bit_cnt_reg == 3'd7) state_next = ST_PARITY;
        end
        ST_PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
          par_ok_next = ^{shift_reg, rx_bit};
`else
          par_ok_next = 1'b1;
`endif
          state_next = ST_STOP;
        end
        ST_STOP: begin
          if (rx_bit && par_ok_reg) begin
            byte_valid_next = 1'b1;
            byte_data_next  = shift_reg;
          end else begin
            frame_err_next = 1'b1;
          end
          state_next = ST_IDLE;
        end
        default: state_next = ST_IDLE;
      endcase
    end else if (state_reg != ST_IDLE && tmo_cnt_reg == TMO_W'(TMO_CYC - 1)) begin
      frame_err_next = 1'b1;
      state_next     = ST_IDLE;
      tmo_cnt_next   = '0;
    end
  end

  // Prefix parser: E1 swallows the remaining 7 bytes of the Pause sequence.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ext_reg  <= 1'b0;
      brk_reg  <= 1'b0;
      skip_reg <= '0;
      key_reg  <= '0;
    end else if (frame_err_reg) begin
      ext_reg <= 1'b0;
      brk_reg <= 1'b0;
    end else if (byte_valid_reg) begin
      if (skip_reg != 3'd0) begin
        skip_reg <= skip_reg - 3'd1;
      end else begin
        case (byte_data_reg)
          8'hE1: begin
            skip_reg <= 3'd7;
            ext_reg  <= 1'b0;
            brk_reg  <= 1'b0;
          end
          8'hE0: ext_reg <= 1'b1;
          8'hF0: brk_reg <= 1'b1;
          8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF: begin
            ext_reg <= 1'b0;
            brk_reg <= 1'b0;
          end
          default: begin
            key_reg <= {~key_reg[10], ~brk_reg, ext_reg, byte_data_reg};
            ext_reg <= 1'b0;
            brk_reg <= 1'b0;
          end
        endcase
      end
    end
  end

  assign ps2.ps2_key    = key_reg;
  assign ps2.byte_valid = byte_valid_reg;
  assign ps2.byte_data  = byte_data_reg;
  assign ps2.frame_err  = frame_err_reg;
endmodule

// File: tb/tb_ps2_key_event_gen.sv
// Self-checking bench for ps2_key_event_gen: directed scenarios plus random frames against a sequence model.
module tb_ps2_key_event_gen;
  localparam int HALF = 20;
`ifdef PS2_PARITY_CHECK_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  ps2_key_event_gen_if ifc();

  ps2_key_event_gen #(.CLK_FREQ(96.0), .FILTER_LEN(8), .TIMEOUT_US(100)) dut (
    .clk(clk), .reset_n(reset_n), .ps2(ifc)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int bv_cnt = 0, fe_cnt = 0, key_chg = 0, lat_err = 0;
  logic [10:0] prev_key;
  logic prev_bv = 1'b0;

  // Pulse counters; a key change must directly follow a byte_valid cycle.
  always @(negedge clk) begin
    if (ifc.byte_valid === 1'b1) bv_cnt <= bv_cnt + 1;
    if (ifc.frame_err === 1'b1) fe_cnt <= fe_cnt + 1;
    if (ifc.ps2_key !== prev_key && reset_n) begin
      key_chg <= key_chg + 1;
      if (prev_bv !== 1'b1) lat_err <= lat_err + 1;
    end
    prev_key <= ifc.ps2_key;
    prev_bv  <= ifc.byte_valid;
  end

  // Reference model of the byte-sequence rules
  logic [10:0] m_key = '0;
  logic [7:0] m_data = '0;
  bit m_ext = 0, m_brk = 0;
  int m_skip = 0;

  task automatic model_reset();
    m_key = '0; m_data = '0; m_ext = 0; m_brk = 0; m_skip = 0;
  endtask

  task automatic model_byte(input logic [7:0] code, input bit bad, output bit good, output bit emit);
    emit = 0;
    good = !(bad && PAR_EN);
    if (!good) begin
      m_ext = 0; m_brk = 0;
      return;
    end
    m_data = code;
    if (m_skip > 0) m_skip--;
    else if (code == 8'hE1) begin m_skip = 7; m_ext = 0; m_brk = 0; end
    else if (code == 8'hE0) m_ext = 1;
    else if (code == 8'hF0) m_brk = 1;
    else if (code inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF}) begin
      m_ext = 0; m_brk = 0;
    end else begin
      m_key = {~m_key[10], ~m_brk, m_ext, code};
      emit = 1; m_ext = 0; m_brk = 0;
    end
  endtask

  function automatic logic [10:0] frame_bits(input logic [7:0] code, input bit bad);
    return {1'b1, (~^code) ^ bad, code, 1'b0};
  endfunction

  // Sends the first n bits of a frame, LSB (start bit) first.
  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      ifc.ps2_data = bits[i];
      ifc.ps2_clk = 1'b1;
      repeat (HALF) @(posedge clk);
      ifc.ps2_clk = 1'b0;
      repeat (HALF) @(posedge clk);
    end
    ifc.ps2_clk = 1'b1;
    repeat (HALF) @(posedge clk);
    ifc.ps2_data = 1'b1;
  endtask

  task automatic do_frame(input logic [7:0] code, input bit bad, input string tag);
    int bv0, fe0, kc0;
    bit good, emit;
    bv0 = bv_cnt; fe0 = fe_cnt; kc0 = key_chg;
    send_bits(frame_bits(code, bad), 11);
    model_byte(code, bad, good, emit);
    @(negedge clk);
    n_checks++;
    if (bv_cnt - bv0 != int'(good)) begin
      n_fail++; $display("FAIL %s byte_valid pulses: got %0d want %0d", tag, bv_cnt - bv0, good);
    end
    n_checks++;
    if (fe_cnt - fe0 != int'(!good)) begin
      n_fail++; $display("FAIL %s frame_err pulses: got %0d want %0d", tag, fe_cnt - fe0, !good);
    end
    n_checks++;
    if (key_chg - kc0 != int'(emit)) begin
      n_fail++; $display("FAIL %s key changes: got %0d want %0d", tag, key_chg - kc0, emit);
    end
    n_checks++;
    if (ifc.ps2_key !== m_key) begin
      n_fail++; $display("FAIL %s ps2_key: got %03h want %03h", tag, ifc.ps2_key, m_key);
    end
    n_checks++;
    if (ifc.byte_data !== m_data) begin
      n_fail++; $display("FAIL %s byte_data: got %02h want %02h", tag, ifc.byte_data, m_data);
    end
    $display("%s: code=%02h bad_par=%0d key=%03h byte_data=%02h", tag, code, bad, ifc.ps2_key, ifc.byte_data);
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks++; if (ifc.ps2_key !== 11'h000) begin n_fail++; $display("FAIL reset ps2_key: got %03h want 000", ifc.ps2_key); end
    n_checks++; if (ifc.byte_valid !== 1'b0) begin n_fail++; $display("FAIL reset byte_valid: got %b want 0", ifc.byte_valid); end
    n_checks++; if (ifc.byte_data !== 8'h00) begin n_fail++; $display("FAIL reset byte_data: got %02h want 00", ifc.byte_data); end
    n_checks++; if (ifc.frame_err !== 1'b0) begin n_fail++; $display("FAIL reset frame_err: got %b want 0", ifc.frame_err); end
    reset_n = 1'b1;
    repeat (30) @(posedge clk);
  endtask

  task automatic test_make();
    do_frame(8'h1C, 0, "make_1C");
    n_checks++; if (ifc.ps2_key !== 11'h61C) begin n_fail++; $display("FAIL make_1C literal key: got %03h want 61C", ifc.ps2_key); end
  endtask

  task automatic test_ext_break();
    do_frame(8'hE0, 0, "ext_E0");
    do_frame(8'hF0, 0, "brk_F0");
    do_frame(8'h75, 0, "brk_75");
    n_checks++; if (ifc.ps2_key !== 11'h175) begin n_fail++; $display("FAIL brk_75 literal key: got %03h want 175", ifc.ps2_key); end
    do_frame(8'h1C, 0, "after_brk");
  endtask

  task automatic test_parity();
    do_frame(8'h29, 1, "bad_parity_29");
  endtask

  task automatic test_framing_errors();
    int fe0;
    fe0 = fe_cnt;
    send_bits(11'h001, 1);
    @(negedge clk);
    n_checks++; if (fe_cnt - fe0 != 1) begin n_fail++; $display("FAIL bad_start frame_err pulses: got %0d want 1", fe_cnt - fe0); end
    m_ext = 0; m_brk = 0;
    fe0 = fe_cnt;
    send_bits({1'b0, ~^8'h33, 8'h33, 1'b0}, 11);
    @(negedge clk);
    n_checks++; if (fe_cnt - fe0 != 1) begin n_fail++; $display("FAIL bad_stop frame_err pulses: got %0d want 1", fe_cnt - fe0); end
    m_ext = 0; m_brk = 0;
    do_frame(8'h24, 0, "after_errs");
  endtask

  task automatic test_timeout();
    int fe0, bv0;
    fe0 = fe_cnt; bv0 = bv_cnt;
    send_bits(frame_bits(8'h5A, 0), 5);
    repeat (9000) @(posedge clk);
    @(negedge clk);
    n_checks++; if (fe_cnt - fe0 != 0) begin n_fail++; $display("FAIL timeout early frame_err: got %0d want 0", fe_cnt - fe0); end
    repeat (800) @(posedge clk);
    @(negedge clk);
    n_checks++; if (fe_cnt - fe0 != 1) begin n_fail++; $display("FAIL timeout frame_err pulses: got %0d want 1", fe_cnt - fe0); end
    n_checks++; if (bv_cnt - bv0 != 0) begin n_fail++; $display("FAIL timeout byte_valid pulses: got %0d want 0", bv_cnt - bv0); end
    m_ext = 0; m_brk = 0;
    do_frame(8'h16, 0, "post_timeout_16");
    n_checks++; if (ifc.ps2_key[7:0] !== 8'h16) begin n_fail++; $display("FAIL post_timeout code: got %02h want 16", ifc.ps2_key[7:0]); end
  endtask

  task automatic test_pause();
    logic [7:0] seq [9];
    seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77, 8'h29};
    for (int i = 0; i < 9; i++) do_frame(seq[i], 0, "pause_seq");
    n_checks++; if (ifc.ps2_key[9:8] !== 2'b10) begin n_fail++; $display("FAIL pause_29 pressed/ext: got %b want 10", ifc.ps2_key[9:8]); end
  endtask

  task automatic test_glitch();
    logic [10:0] bits;
    int bv0, fe0;
    bit good, emit;
    ifc.ps2_data = 1'b0;
    ifc.ps2_clk = 1'b0;
    repeat (3) @(posedge clk);
    ifc.ps2_clk = 1'b1;
    repeat (40) @(posedge clk);
    ifc.ps2_data = 1'b1;
    bv0 = bv_cnt; fe0 = fe_cnt;
    bits = frame_bits(8'h4B, 0);
    for (int i = 0; i < 11; i++) begin
      ifc.ps2_data = bits[i];
      ifc.ps2_clk = 1'b1;
      repeat (HALF / 2) @(posedge clk);
      if (i == 5) begin
        ifc.ps2_clk = 1'b0;
        repeat (3) @(posedge clk);
        ifc.ps2_clk = 1'b1;
      end
      repeat (HALF / 2) @(posedge clk);
      ifc.ps2_clk = 1'b0;
      repeat (HALF) @(posedge clk);
    end
    ifc.ps2_clk = 1'b1;
    repeat (HALF) @(posedge clk);
    ifc.ps2_data = 1'b1;
    model_byte(8'h4B, 0, good, emit);
    @(negedge clk);
    n_checks++; if (bv_cnt - bv0 != 1) begin n_fail++; $display("FAIL glitch byte_valid pulses: got %0d want 1", bv_cnt - bv0); end
    n_checks++; if (fe_cnt - fe0 != 0) begin n_fail++; $display("FAIL glitch frame_err pulses: got %0d want 0", fe_cnt - fe0); end
    n_checks++; if (ifc.ps2_key !== m_key) begin n_fail++; $display("FAIL glitch ps2_key: got %03h want %03h", ifc.ps2_key, m_key); end
    $display("glitch: code=4B key=%03h", ifc.ps2_key);
  endtask

  task automatic test_reset_midframe();
    int fe0;
    fe0 = fe_cnt;
    send_bits(frame_bits(8'h33, 0), 4);
    reset_n = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    n_checks++; if ({ifc.ps2_key, ifc.byte_valid, ifc.byte_data, ifc.frame_err} !== 21'd0) begin
      n_fail++; $display("FAIL midframe_reset outputs: got key=%03h bv=%b bd=%02h fe=%b want all 0", ifc.ps2_key, ifc.byte_valid, ifc.byte_data, ifc.frame_err);
    end
    reset_n = 1'b1;
    model_reset();
    repeat (50) @(posedge clk);
    @(negedge clk);
    n_checks++; if (fe_cnt - fe0 != 0) begin n_fail++; $display("FAIL midframe_reset frame_err pulses: got %0d want 0", fe_cnt - fe0); end
    do_frame(8'h1C, 0, "post_reset_1C");
  endtask

  task automatic test_random();
    logic [7:0] code;
    bit bad;
    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 9))
        0: code = 8'hE0;
        1: code = 8'hF0;
        2: code = ($urandom_range(0, 3) == 0) ? 8'hE1 : 8'hAA;
        default: code = 8'($urandom_range(0, 255));
      endcase
      bad = ($urandom_range(0, 7) == 0);
      do_frame(code, bad, "random");
    end
    n_checks++; if (lat_err != 0) begin n_fail++; $display("FAIL key latency: got %0d stray key changes want 0", lat_err); end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    ifc.ps2_clk = 1'b1;
    ifc.ps2_data = 1'b1;
    reset_n = 1'b0;
    repeat (5) @(posedge clk);
    test_reset();
    test_make();
    test_ext_break();
    test_parity();
    test_framing_errors();
    test_timeout();
    test_pause();
    test_glitch();
    test_reset_midframe();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/ps2_key_event_gen.md
# ps2_key_event_gen

Converts a raw PS/2 keyboard serial stream into the 11-bit toggle-format key event word consumed by the core's keyboard handler. It sits between the physical PS/2 keyboard pins and the control logic in place of the HPS-supplied `ps2_key` bus. It is used for standalone and bench builds where no HPS is present. It receives device-to-host frames, assembles make/break/extended sequences, and publishes one event word per completed key transition.

## Interface
Parameters:
- CLK_FREQ, 96.0: system clock frequency in MHz (real).
- FILTER_LEN, 8: consecutive equal samples required before the filtered `ps2_clk` changes level.
- TIMEOUT_US, 100: maximum gap in microseconds between falling clock edges within one frame.

Ports:
- clk  in  1  system clock; all logic is on its rising edge.
- reset_n  in  1  synchronous, active-low reset.
- ps2_clk  in  1  raw keyboard clock; asynchronous to `clk`.
- ps2_data  in  1  raw keyboard data; asynchronous to `clk`.
- ps2_key  out  11  event word:
  - [10] toggles on each new event.
  - [9] pressed: 1 = make, 0 = break.
  - [8] extended (E0 prefix seen).
  - [7:0] scan code.
- byte_valid  out  1  one-cycle pulse when a frame is received without error.
- byte_data  out  8  last good received byte; held until the next good frame.
- frame_err  out  1  one-cycle pulse on a start, parity, stop or timeout error.

## Operation
- Input conditioning:
  - `ps2_clk` and `ps2_data` each pass through a 2-flop synchronizer.
  - The clock is then glitch-filtered: its filtered level changes only after FILTER_LEN identical synchronized samples.
  - A falling edge of the filtered clock is the bit strobe. Data is sampled on that strobe.
- Receiver states: IDLE, DATA, PARITY, STOP.
  - IDLE: on a strobe, data 0 goes to DATA with bit count 0. Data 1 pulses frame_err and stays in IDLE.
  - DATA: shift in 8 bits, LSB first, then go to PARITY.
  - PARITY: the sampled bit combined with the 8 data bits must give odd parity (see Configuration). Go to STOP.
  - STOP: data 1 with parity OK pulses byte_valid and loads byte_data. Otherwise pulse frame_err. Go to IDLE in both cases.
  - Timeout: in any state except IDLE, a timeout counter of CLK_FREQ*TIMEOUT_US cycles (integer, truncated) restarts on each strobe. On expiry, pulse frame_err and go to IDLE.
- Sequence parser. Its state is the `ext`, `brk` and `skip[2:0]` registers. Each good byte is handled as follows:
  - If skip != 0: decrement skip; emit nothing.
  - E1: set skip = 7, clear ext and brk. This swallows the Pause sequence.
  - E0: set ext. F0: set brk. Either order is accepted, and repeats are idempotent.
  - 00, AA, EE, FA, FC, FD, FE, FF: emit nothing; clear ext and brk.
  - Any other code: ps2_key <= {~ps2_key[10], ~brk, ext, code}, then clear ext and brk.
- A frame_err clears ext and brk. It does not change skip.

## Timing
- Reset values: ps2_key = 0, byte_valid = 0, byte_data = 0, frame_err = 0. On reset the receiver goes to IDLE; ext, brk, skip and the timeout counter are cleared; filter history is set to 1 (bus idle).
- Edge latency: 2 synchronizer cycles plus FILTER_LEN cycles from a pin transition to the filtered falling edge. The strobe is asserted the following cycle.
- byte_valid and frame_err are asserted in the cycle after the stop-bit strobe. The timeout frame_err is asserted in the cycle after the counter expires.
- ps2_key changes exactly 1 cycle after byte_valid, and at most once per frame.
- A strobe and a timeout expiry in the same cycle: the strobe wins.
- If reset_n is deasserted mid-frame, the partial frame is discarded silently (no frame_err). The next start bit is received normally.

## Configuration
- PS2_PARITY_CHECK_EN:
  - Defined: a parity mismatch in PARITY causes frame_err in STOP, and the byte is discarded.
  - Undefined: the parity bit is sampled and ignored. Only start, stop and timeout errors are reported.

## Test plan
- Reset, then frame 0x1C: byte_valid pulses with byte_data = 0x1C; next cycle ps2_key = 0x61C (toggle 1, pressed, not extended).
- Frames E0 F0 75 after the previous test: one event only, ps2_key = 0x175 (toggle 0, released, extended); ext and brk are clear afterwards.
- With PS2_PARITY_CHECK_EN, frame 0x29 with even parity: frame_err pulses once, and ps2_key and byte_data are unchanged. Without the macro: ps2_key = {~t,1,0,0x29}.
- Send start + 4 data bits, then idle for more than TIMEOUT_US: frame_err pulses at expiry and the receiver is back in IDLE; a following frame 0x16 gives ps2_key[7:0] = 0x16.
- Pause sequence E1 14 77 E1 F0 14 F0 77, then 0x29: no ps2_key change for the 8 bytes; 0x29 produces a make event with ext = 0.
- Inject a 3-cycle low glitch on ps2_clk (FILTER_LEN = 8): no strobe is generated and no bit is counted. Assert reset_n low mid-frame: all outputs read 0 and frame_err stays low.
